// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, functs, FSM states, ALU control codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    MEM,
    WB,
    DONE
  } state_t;

  // Maps an R-type funct to its ALU control; unsupported functs report legal=0.
  function automatic logic [4:0] rtype_decode(input logic [5:0] funct);
    logic [4:0] r;
    case (funct)
      FN_ADD:  r = {1'b1, ALU_ADD};
      FN_SUB:  r = {1'b1, ALU_SUB};
      FN_AND:  r = {1'b1, ALU_AND};
      FN_OR:   r = {1'b1, ALU_OR};
      FN_NOR:  r = {1'b1, ALU_NOR};
      FN_SLT:  r = {1'b1, ALU_SLT};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_multicycle_core_alu.sv
// Combinational ALU for the multicycle core; slt compares signed and zero-extends its 1-bit result.
module mips_alu
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        alu_ctl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_ctl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = DATA_W'($signed(a) < $signed(b));
      ALU_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core (add/sub/and/or/nor/slt, lw, sw; addi when MIPS_ADDI_EN is defined).
// Latency accept->done: R-type 4, sw 4, lw 5, addi 4, illegal 2.
// Backpressure: instr_ready is high only in IDLE, so a sender holds its word until the core retires.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int MEM_AW   = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instrword,
  output logic              instr_ready,
  output logic              done,
  output logic              illegal,
  input  logic [4:0]        dbg_reg_addr,
  output logic [DATA_W-1:0] dbg_reg_data
);

  localparam int MEM_DEPTH = 2 ** MEM_AW;

  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic              illegal_q, illegal_d;

  // Full 32-entry array; entries at or above NUM_REGS are never written and stay zero.
  logic [DATA_W-1:0] rf_q [32];
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];

  logic       dec_legal, dec_rtype, dec_lw, dec_sw, dec_alu_src;
  logic [3:0] dec_alu_ctl;
  logic [4:0] rtype_info;
  assign rtype_info = rtype_decode(funct);

  always_comb begin
    dec_legal   = 1'b0;
    dec_rtype   = 1'b0;
    dec_lw      = 1'b0;
    dec_sw      = 1'b0;
    dec_alu_src = 1'b0;
    dec_alu_ctl = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        dec_rtype   = 1'b1;
        dec_legal   = rtype_info[4];
        dec_alu_ctl = rtype_info[3:0];
      end
      OP_LW: begin
        dec_legal   = 1'b1;
        dec_lw      = 1'b1;
        dec_alu_src = 1'b1;
      end
      OP_SW: begin
        dec_legal   = 1'b1;
        dec_sw      = 1'b1;
        dec_alu_src = 1'b1;
      end
`ifdef MIPS_ADDI_EN
      OP_ADDI: begin
        dec_legal   = 1'b1;
        dec_alu_src = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= NUM_REGS) return '0;
    return rf_q[idx];
  endfunction

  assign dbg_reg_data = rf_read(dbg_reg_addr);

  logic [DATA_W-1:0] imm_sext, alu_b, alu_y;
  assign imm_sext = DATA_W'(signed'(ir_q[15:0]));
  assign alu_b    = dec_alu_src ? imm_sext : b_q;

  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_ctl (dec_alu_ctl),
    .a       (a_q),
    .b       (alu_b),
    .y       (alu_y)
  );

  logic [MEM_AW-1:0] mem_idx;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rf_we, mem_we;
  assign mem_idx = alu_out_q[MEM_AW+1:2];
  assign wb_addr = dec_rtype ? rd : rt;
  assign wb_data = dec_lw ? mdr_q : alu_out_q;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d      = instrword;
          illegal_d = 1'b0;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        a_d = rf_read(rs);
        b_d = rf_read(rt);
        if (dec_legal) begin
          state_d = EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = DONE;
        end
      end
      EXEC: begin
        alu_out_d = alu_y;
        state_d   = (dec_lw || dec_sw) ? MEM : WB;
      end
      MEM: begin
        if (dec_lw) begin
          mdr_d   = mem_q[mem_idx];
          state_d = WB;
        end else begin
          mem_we  = 1'b1;
          state_d = DONE;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
      if (rf_we && wb_addr != 5'd0 && int'(wb_addr) < NUM_REGS) rf_q[wb_addr] <= wb_data;
      if (mem_we) mem_q[mem_idx] <= b_q;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign illegal     = done && illegal_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed scenarios plus random instructions against an ISA-level model.
module tb_mips_multicycle_core;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int MEM_AW   = 7;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instrword;
  logic        instr_ready;
  logic        done;
  logic        illegal;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;

  mips_multicycle_core #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .MEM_AW(MEM_AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instrword    (instrword),
    .instr_ready  (instr_ready),
    .done         (done),
    .illegal      (illegal),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_rf  [32];
  logic [31:0] m_mem [2**MEM_AW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    for (int i = 0; i < 2**MEM_AW; i++) m_mem[i] = '0;
  endtask

  task automatic model_wr(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 5'd0 && int'(idx) < NUM_REGS) m_rf[idx] = v;
  endtask

  // ISA-level effect of one instruction, plus the cycle count it should take.
  task automatic model_step(input logic [31:0] ins, output int lat, output bit ill);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] va, vb, sx, res, addr;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
    sx = {{16{ins[15]}}, ins[15:0]};
    va = m_rf[rs]; vb = m_rf[rt]; addr = va + sx; res = '0;
    lat = 2; ill = 1'b1;
    if (op == 6'd0) begin
      lat = 4; ill = 1'b0;
      case (fn)
        6'd32: res = va + vb;
        6'd34: res = va - vb;
        6'd36: res = va & vb;
        6'd37: res = va | vb;
        6'd39: res = ~(va | vb);
        6'd42: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
        default: begin lat = 2; ill = 1'b1; end
      endcase
      if (!ill) model_wr(rd, res);
    end else if (op == 6'd35) begin
      lat = 5; ill = 1'b0;
      model_wr(rt, m_mem[addr[MEM_AW+1:2]]);
    end else if (op == 6'd43) begin
      lat = 4; ill = 1'b0;
      m_mem[addr[MEM_AW+1:2]] = vb;
    end
`ifdef MIPS_ADDI_EN
    else if (op == 6'd8) begin
      lat = 4; ill = 1'b0;
      model_wr(rt, addr);
    end
`endif
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ins);
    int exp_lat, lat;
    bit exp_ill, got_ill;
    model_step(ins, exp_lat, exp_ill);
    @(negedge clock);
    check({tag, " ready"}, 32'(instr_ready), 32'd1);
    check({tag, " done idle"}, 32'(done), 32'd0);
    instrword   = ins;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    lat = 0; got_ill = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k; got_ill = illegal;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " illegal"}, 32'(got_ill), 32'(exp_ill));
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
    dbg_reg_addr = 5'(idx);
    #1;
    check(tag, dbg_reg_data, exp);
  endtask

  task automatic dump_regs(input string tag);
    for (int r = 0; r < 32; r++) check_reg($sformatf("%s r%0d", tag, r), r, m_rf[r]);
  endtask

  initial begin
    int          kind, exp_lat, exp_ill_i;
    bit          exp_ill;
    logic [31:0] ins;
    int          fns [6];
    int          bad_fns [5];
    int          op;
    fns     = '{32, 34, 36, 37, 39, 42};
    bad_fns = '{0, 33, 35, 38, 43};

    reset = 1'b1; instr_valid = 1'b0; instrword = '0; dbg_reg_addr = '0;
    model_clear();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset ready", 32'(instr_ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    dump_regs("reset");

    run_instr("sw0", enc_i(43, 0, 0, 0));
    run_instr("lw r1", enc_i(35, 0, 1, 0));
    check_reg("lw r1 value", 1, 32'd0);

    run_instr("nor r9", enc_r(0, 0, 9, 39));
    run_instr("sub r13", enc_r(0, 9, 13, 34));
    run_instr("add r14", enc_r(13, 13, 14, 32));
    run_instr("add r15", enc_r(14, 14, 15, 32));
    run_instr("add r16", enc_r(15, 14, 16, 32));
    run_instr("add r17", enc_r(16, 13, 17, 32));
    run_instr("sw r17", enc_i(43, 0, 17, 8));
    run_instr("lw r2", enc_i(35, 0, 2, 8));
    run_instr("add r18", enc_r(15, 13, 18, 32));
    run_instr("sw r18", enc_i(43, 0, 18, 12));
    run_instr("lw r3", enc_i(35, 0, 3, 12));
    check_reg("r2 seven", 2, 32'd7);
    check_reg("r3 five", 3, 32'd5);
    run_instr("add r4", enc_r(2, 3, 4, 32));
    check_reg("add r4", 4, 32'd12);
    run_instr("sub r5", enc_r(3, 2, 5, 34));
    check_reg("sub r5", 5, 32'hFFFF_FFFE);

    run_instr("nor r6", enc_r(0, 0, 6, 39));
    run_instr("sub r7", enc_r(0, 6, 7, 34));
    run_instr("slt r8 a", enc_r(6, 7, 8, 42));
    check_reg("slt signed", 8, 32'd1);
    run_instr("slt r8 b", enc_r(7, 6, 8, 42));
    check_reg("slt reverse", 8, 32'd0);
    run_instr("nor r9", enc_r(0, 0, 9, 39));
    check_reg("nor r9", 9, 32'hFFFF_FFFF);

    run_instr("sw wrap", enc_i(43, 0, 4, 'h204));
    run_instr("lw r10", enc_i(35, 0, 10, 4));
    check_reg("mem wrap", 10, 32'd12);
    run_instr("add r0", enc_r(2, 3, 0, 32));
    check_reg("r0 stays", 0, 32'd0);

    run_instr("op3f", enc_i('h3F, 2, 3, 'h1234));
    run_instr("bad funct", enc_r(2, 3, 12, 33));
    run_instr("addi", enc_i(8, 0, 11, -3));
`ifdef MIPS_ADDI_EN
    check_reg("addi r11", 11, 32'hFFFF_FFFD);
`else
    check_reg("addi r11", 11, 32'd0);
`endif
    dump_regs("directed");

    // Valid held high: one accept per IDLE visit, add period is latency+1 = 5.
    for (int i = 0; i < 3; i++) model_step(enc_r(2, 3, 19, 32), exp_lat, exp_ill);
    @(negedge clock);
    instrword = enc_r(2, 3, 19, 32); instr_valid = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      check($sformatf("hold done c%0d", k), 32'(done), 32'((k % 5) == 4));
      check($sformatf("hold ready c%0d", k), 32'(instr_ready), 32'((k % 5) == 0));
      if (k == 14) instr_valid = 1'b0;
    end
    dump_regs("hold");

    // Reset while in EXEC of an add.
    @(negedge clock);
    instrword = enc_r(2, 3, 20, 32); instr_valid = 1'b1;
    @(posedge clock);
    #1 instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("abort done c%0d", k), 32'(done), 32'd0);
      check($sformatf("abort ready c%0d", k), 32'(instr_ready), 32'd1);
      @(negedge clock);
    end
    dump_regs("abort");

    for (int i = 0; i < 60; i++) begin
      kind = (i < 6) ? 0 : int'($urandom_range(0, 9));
      case (kind)
        0, 1, 2, 3, 4:
          ins = enc_r($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      (i < 6) ? ((i % 2) ? 34 : 39) : fns[$urandom_range(0, 5)]);
        5: ins = enc_i(35, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
        6: ins = enc_i(43, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
        7: ins = enc_r($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31),
                       bad_fns[$urandom_range(0, 4)]);
        8: begin
          op = int'($urandom_range(1, 63));
          if (op == 35 || op == 43) op = 63;
          ins = enc_i(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
        end
        default: ins = enc_i(8, $urandom_range(0, 31), $urandom_range(1, 31), $urandom_range(0, 65535));
      endcase
      run_instr($sformatf("rand%0d", i), ins);
      dump_regs($sformatf("rand%0d", i));
    end

    exp_ill_i = 0;
    if (exp_ill_i != 0) $display("unused");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
